// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/long/repeat(/double) pulses
// and keeps a wrapping press counter. Optional double-click detection: define BTN_DOUBLE_CLICK_EN.
module button_event_decoder #(
    parameter int LONG_LIMIT    = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int DBL_WINDOW    = 25_000_000,
    parameter int CNT_W         = 26,
    parameter int PCNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_switch,
    output logic              o_press,
    output logic              o_release,
    output logic              o_long,
    output logic              o_repeat,
    output logic              o_double,
    output logic [PCNT_W-1:0] o_press_count
);
`ifdef BTN_DOUBLE_CLICK_EN
    typedef enum logic [1:0] {IDLE, PRESSED, HELD, WAIT2} state_t;
    localparam logic [CNT_W-1:0] DBL_T = CNT_W'(DBL_WINDOW - 1);
`else
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
`endif
    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_LIMIT - 1);
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_PERIOD - 1);
    localparam int MAX_LR = (LONG_LIMIT > REPEAT_PERIOD) ? LONG_LIMIT : REPEAT_PERIOD;
    localparam int MAX_T  = (MAX_LR > DBL_WINDOW) ? MAX_LR : DBL_WINDOW;
    if (CNT_W < $clog2(MAX_T + 1)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured timer limits");
    end
    state_t             state, state_n;
    logic               r_prev;
    logic [CNT_W-1:0]   timer, timer_n;
    logic               press_n, release_n, long_n, repeat_n, double_n;
    logic               rise, fall;
    assign rise = i_switch & ~r_prev;
    assign fall = ~i_switch & r_prev;
    // next state, timer and event pulses; a fall always wins over a terminal count
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        double_n  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    press_n = 1'b1;
                    timer_n = '0;
                    state_n = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_n = 1'b1;
                    timer_n   = '0;
`ifdef BTN_DOUBLE_CLICK_EN
                    state_n   = WAIT2;
`else
                    state_n   = IDLE;
`endif
                end else if (timer == LONG_T) begin
                    long_n  = 1'b1;
                    timer_n = '0;
                    state_n = HELD;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    release_n = 1'b1;
                    timer_n   = '0;
                    state_n   = IDLE;
                end else if (timer == REP_T) begin
                    repeat_n = 1'b1;
                    timer_n  = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            WAIT2: begin
                if (rise) begin
                    press_n  = 1'b1;
                    double_n = 1'b1;
                    timer_n  = '0;
                    state_n  = PRESSED;
                end else if (timer == DBL_T) begin
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`endif
            default: begin
                timer_n = '0;
                state_n = IDLE;
            end
        endcase
    end
    // state, edge history, registered pulses and press counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            r_prev        <= 1'b0;
            timer         <= '0;
            o_press       <= 1'b0;
            o_release     <= 1'b0;
            o_long        <= 1'b0;
            o_repeat      <= 1'b0;
            o_double      <= 1'b0;
            o_press_count <= '0;
        end else begin
            state         <= state_n;
            r_prev        <= i_switch;
            timer         <= timer_n;
            o_press       <= press_n;
            o_release     <= release_n;
            o_long        <= long_n;
            o_repeat      <= repeat_n;
            o_double      <= double_n;
            o_press_count <= press_n ? o_press_count + 1'b1 : o_press_count;
        end
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: vector table, hand sequences and random stimulus against an event-level model
module tb_button_event_decoder;
    localparam int LL = 8;
    localparam int RP = 4;
    localparam int DW = 6;
`ifdef BTN_DOUBLE_CLICK_EN
    localparam bit DBL_ON = 1'b1;
`else
    localparam bit DBL_ON = 1'b0;
`endif
    localparam logic [4:0] EV_P = 5'b10000;
    localparam logic [4:0] EV_R = 5'b01000;
    localparam logic [4:0] EV_L = 5'b00100;
    localparam logic [4:0] EV_T = 5'b00010;
    localparam logic [4:0] EV_D = 5'b00001;

    logic clk, rst_n, i_switch;
    logic o_press, o_release, o_long, o_repeat, o_double;
    logic [7:0] o_press_count;
    logic [12:0] act;
    assign act = {o_press, o_release, o_long, o_repeat, o_double, o_press_count};

    button_event_decoder #(
        .LONG_LIMIT(LL), .REPEAT_PERIOD(RP), .DBL_WINDOW(DW), .CNT_W(8), .PCNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_switch(i_switch),
        .o_press(o_press), .o_release(o_release), .o_long(o_long),
        .o_repeat(o_repeat), .o_double(o_double), .o_press_count(o_press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // event-level reference: tracks press start / release edge numbers, not FSM states
    int n = 0;
    bit m_prev, m_in, m_armed;
    int m_press_n, m_rel_n;
    logic [7:0] m_cnt;
    logic [4:0] m_exp;

    task automatic chk(input string name, input logic [12:0] a, input logic [12:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s edge=%0d got ev=%b cnt=%0d want ev=%b cnt=%0d",
                     name, n, a[12:8], a[7:0], e[12:8], e[7:0]);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_in = 0; m_armed = 0; m_cnt = 0; m_exp = 0;
    endtask

    task automatic model_edge(input bit s);
        int h;
        m_exp = 0;
        if (m_in) begin
            h = n - m_press_n;
            if (!s) begin
                m_exp = EV_R;
                m_in = 0;
                m_armed = (h <= LL);
                m_rel_n = n;
            end else if (h == LL) m_exp = EV_L;
            else if (h > LL && (h - LL) % RP == 0) m_exp = EV_T;
        end else if (s && !m_prev) begin
            m_exp = EV_P;
            m_cnt = m_cnt + 8'd1;
            if (DBL_ON && m_armed && (n - m_rel_n) <= DW) m_exp = m_exp | EV_D;
            m_in = 1;
            m_armed = 0;
            m_press_n = n;
        end
        m_prev = s;
        n++;
    endtask

    task automatic step(input bit s);
        i_switch = s;
        @(posedge clk);
        model_edge(s);
        #1;
        chk("model", act, {m_exp, m_cnt});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_async", act, 13'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", act, 13'd0);
        rst_n = 1'b1;
    endtask

    task automatic seq_double(input int hold1, input int gap, input bit want);
        repeat (10) step(0);
        repeat (hold1) step(1);
        repeat (gap) step(0);
        step(1);
        chk($sformatf("dbl_h%0d_g%0d", hold1, gap), {8'd0, o_double, 4'd0}, {8'd0, want, 4'd0});
        step(1);
        step(0);
    endtask

    typedef struct {
        logic       sw;
        logic [4:0] ev;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic push(input logic sw, input logic [4:0] ev, input logic [7:0] cnt, input int times);
        vec_t v;
        v.sw = sw; v.ev = ev; v.cnt = cnt;
        repeat (times) tbl.push_back(v);
    endtask

    initial begin
        logic [4:0] ev;
        bit lvl;
        int len;
        rst_n = 1'b1;
        i_switch = 1'b0;
        #3;
        do_reset();

        push(0, 0, 0, 10);
        push(1, EV_P, 1, 1); push(1, 0, 1, 2); push(0, EV_R, 1, 1); push(0, 0, 1, 8);
        push(1, EV_P, 2, 1); push(1, 0, 2, 7); push(0, EV_R, 2, 1); push(0, 0, 2, 8);
        foreach (tbl[i]) begin
            step(tbl[i].sw);
            chk($sformatf("vec%0d", i), act, {tbl[i].ev, tbl[i].cnt});
        end

        for (int k = 0; k <= 20; k++) begin
            step(1);
            ev = (k == 0) ? EV_P : (k == LL) ? EV_L :
                 (k > LL && (k - LL) % RP == 0) ? EV_T : 5'b0;
            chk($sformatf("hold%0d", k), act, {ev, 8'd3});
        end
        step(0);
        chk("hold_release", act, {EV_R, 8'd3});
        repeat (10) step(0);

        for (int i = 0; i < 252; i++) begin
            step(1); step(1); step(0); step(0);
        end
        chk("wrap255", {5'd0, o_press_count}, {5'd0, 8'd255});
        repeat (8) step(0);
        step(1);
        chk("wrap0", {5'd0, o_press_count}, 13'd0);
        step(1);
        step(1);
        do_reset();
        step(1);
        chk("rst_press", act, {EV_P, 8'd1});
        step(1);
        step(0);

        seq_double(2, 4, DBL_ON);
        seq_double(2, 7, 1'b0);
        seq_double(2, 6, DBL_ON);
        seq_double(12, 2, 1'b0);

        lvl = 0;
        for (int i = 0; i < 300; i++) begin
            lvl = ~lvl;
            len = ($urandom % 4 == 0) ? $urandom_range(1, 30) : $urandom_range(1, 8);
            repeat (len) step(lvl);
        end
        repeat (12) step(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
